axis_splitter: RTL and testbench

AXIS_SPLITTER -- requirements
Module: axis_splitter

---
 rtl/axis_splitter.sv | 173 +++++++++++++++++
 tb/tb_axis_splitter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_splitter.sv
// Splits each input AXI-Stream packet into NUM_STREAMS consecutive segments, segment i out on stream i.
// Latency: zero; data and tlast pass combinationally, only routing state and error pulses are registered.
// Backpressure: input tready follows the selected output's tready; excess beats after the last segment are sunk.
module axis_splitter #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_STREAMS    = 2,
    parameter int LEN_BITS       = 16
) (
    input  logic                                  clk,
    input  logic                                  areset,
    input  logic [NUM_STREAMS*LEN_BITS-1:0]       seg_beats,
    output logic                                  axis_i_tready,
    input  logic                                  axis_i_tvalid,
    input  logic                                  axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]               axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0]             axis_i_tuser,
    input  logic [NUM_STREAMS-1:0]                axis_o_tready,
    output logic [NUM_STREAMS-1:0]                axis_o_tvalid,
    output logic [NUM_STREAMS-1:0]                axis_o_tlast,
    output logic [NUM_STREAMS*AXIS_BYTES*8-1:0]   axis_o_tdata,
    output logic [NUM_STREAMS*AXIS_USER_BITS-1:0] axis_o_tuser,
    output logic                                  err_short,
    output logic                                  err_long
);

    localparam int IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STREAMS - 1);

    typedef enum logic {
        ROUTE = 1'b0,
        DROP  = 1'b1
    } mode_t;

    // Routing state
    mode_t                       r_mode;
    mode_t                       w_mode_nxt;
    logic [IDX_W-1:0]            r_idx;
    logic [IDX_W-1:0]            w_idx_nxt;
    logic [LEN_BITS-1:0]         r_beat;
    logic [LEN_BITS-1:0]         w_beat_nxt;

    // Packet tracking: lengths frozen for the remainder of a packet once it has started
    logic [NUM_STREAMS*LEN_BITS-1:0] r_len;
    logic                            r_in_pkt;

    // Error pulses
    logic r_err_short;
    logic r_err_long;
    logic w_err_short_nxt;
    logic w_err_long_nxt;

    // Datapath helpers
    logic [NUM_STREAMS*LEN_BITS-1:0] w_len_src;
    logic [LEN_BITS-1:0]             w_len [NUM_STREAMS];
    logic [LEN_BITS-1:0]             w_cur_len;
    logic                            w_seg_end;
    logic                            w_o_last;
    logic                            w_hs;

    // The first beat of a packet sees the live lengths; later beats see the frozen copy.
    assign w_len_src = r_in_pkt ? r_len : seg_beats;

    // A zero-length field still carries one beat, so every stream gets a packet.
    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_len
        logic [LEN_BITS-1:0] w_raw;
        assign w_raw    = w_len_src[g*LEN_BITS +: LEN_BITS];
        assign w_len[g] = (w_raw == '0) ? LEN_BITS'(1) : w_raw;
    end

    assign w_cur_len = w_len[r_idx];
    assign w_seg_end = (r_beat == (w_cur_len - LEN_BITS'(1)));
    assign w_o_last  = axis_i_tlast | w_seg_end;
    assign w_hs      = axis_i_tvalid & axis_i_tready;

    // Payload is broadcast; only the selected tvalid qualifies it.
    assign axis_o_tdata = {NUM_STREAMS{axis_i_tdata}};
    assign axis_o_tuser = {NUM_STREAMS{axis_i_tuser}};

    assign err_short = r_err_short;
    assign err_long  = r_err_long;

    // Handshake steering: selected stream in ROUTE, unconditional sink in DROP, idle while in reset
    always_comb begin
        axis_o_tvalid = '0;
        axis_o_tlast  = '0;
        axis_i_tready = 1'b0;
        if (!areset) begin
            if (r_mode == ROUTE) begin
                axis_o_tvalid[r_idx] = axis_i_tvalid;
                axis_o_tlast[r_idx]  = w_o_last;
                axis_i_tready        = axis_o_tready[r_idx];
            end else begin
                axis_i_tready = 1'b1;
            end
        end
    end

    // Next-state logic: advance beat/stream on each accepted beat and flag length mismatches
    always_comb begin
        w_mode_nxt      = r_mode;
        w_idx_nxt       = r_idx;
        w_beat_nxt      = r_beat;
        w_err_short_nxt = 1'b0;
        w_err_long_nxt  = 1'b0;
        if (w_hs) begin
            case (r_mode)
                ROUTE: begin
                    if (!w_o_last) begin
                        w_beat_nxt = r_beat + LEN_BITS'(1);
                    end else if (axis_i_tlast) begin
                        // Input ended: short unless it landed exactly on the final segment's end
                        w_idx_nxt       = '0;
                        w_beat_nxt      = '0;
                        w_err_short_nxt = (r_idx != LAST_IDX) || !w_seg_end;
                    end else if (r_idx != LAST_IDX) begin
                        w_idx_nxt  = r_idx + IDX_W'(1);
                        w_beat_nxt = '0;
                    end else begin
                        // All segments delivered but input continues: sink the tail
                        w_mode_nxt     = DROP;
                        w_idx_nxt      = '0;
                        w_beat_nxt     = '0;
                        w_err_long_nxt = 1'b1;
                    end
                end
                DROP: begin
                    if (axis_i_tlast) begin
                        w_mode_nxt = ROUTE;
                        w_idx_nxt  = '0;
                        w_beat_nxt = '0;
                    end
                end
                default: begin
                    w_mode_nxt = ROUTE;
                    w_idx_nxt  = '0;
                    w_beat_nxt = '0;
                end
            endcase
        end
    end

    // Routing state and error pulse registers
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_mode      <= ROUTE;
            r_idx       <= '0;
            r_beat      <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_idx       <= w_idx_nxt;
            r_beat      <= w_beat_nxt;
            r_err_short <= w_err_short_nxt;
            r_err_long  <= w_err_long_nxt;
        end
    end

    // Packet boundary tracking and length capture on the first accepted beat
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_in_pkt <= 1'b0;
            r_len    <= '0;
        end else if (w_hs) begin
            r_in_pkt <= !axis_i_tlast;
            if (!r_in_pkt) begin
                r_len <= seg_beats;
            end
        end
    end

endmodule

// File: tb/tb_axis_splitter.sv
module tb_axis_splitter;

    localparam int NS = 2;
    localparam int LB = 16;
    localparam int DW = 8;
    localparam int UW = 1;

    logic                 clk = 1'b0;
    logic                 areset;
    logic [NS*LB-1:0]     seg_beats;
    logic                 i_tready;
    logic                 i_tvalid;
    logic                 i_tlast;
    logic [DW-1:0]        i_tdata;
    logic [UW-1:0]        i_tuser;
    logic [NS-1:0]        o_tready;
    logic [NS-1:0]        o_tvalid;
    logic [NS-1:0]        o_tlast;
    logic [NS*DW-1:0]     o_tdata;
    logic [NS*UW-1:0]     o_tuser;
    logic                 err_short;
    logic                 err_long;

    axis_splitter #(
        .AXIS_BYTES(DW/8), .AXIS_USER_BITS(UW), .NUM_STREAMS(NS), .LEN_BITS(LB)
    ) dut (
        .clk(clk), .areset(areset), .seg_beats(seg_beats),
        .axis_i_tready(i_tready), .axis_i_tvalid(i_tvalid), .axis_i_tlast(i_tlast),
        .axis_i_tdata(i_tdata), .axis_i_tuser(i_tuser),
        .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid), .axis_o_tlast(o_tlast),
        .axis_o_tdata(o_tdata), .axis_o_tuser(o_tuser),
        .err_short(err_short), .err_long(err_long)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t         exp_q [NS][$];
    logic [DW-1:0] pkt_d [$];
    logic [UW-1:0] pkt_u [$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_viol   = 0;
    int n_short_obs = 0, n_long_obs = 0;
    int exp_short   = 0, exp_long   = 0;
    int bp_mode = 0;               // 0: all ready, 1: random, 2: follow man_rdy
    logic [NS-1:0] man_rdy = '1;

    // Output backpressure source
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode == 0)      o_tready = '1;
            else if (bp_mode == 1) o_tready = NS'($urandom);
            else                   o_tready = man_rdy;
        end
    end

    // Scoreboard: every output handshake must match the next expected beat of that stream
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (o_tvalid[i] && o_tready[i]) begin
                beat_t got;
                beat_t want;
                got.d = o_tdata[i*DW +: DW];
                got.u = o_tuser[i*UW +: UW];
                got.l = o_tlast[i];
                n_checks++;
                if (exp_q[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL s%0d_unexpected: got d=%h u=%h l=%b, required no beat", i, got.d, got.u, got.l);
                end else begin
                    want = exp_q[i].pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL s%0d_beat: got d=%h u=%h l=%b, required d=%h u=%h l=%b",
                                 i, got.d, got.u, got.l, want.d, want.u, want.l);
                    end
                end
            end
        end
        if ($countones(o_tvalid) > 1) n_viol++;
        if (err_short && err_long) n_viol++;
        if (err_short) n_short_obs++;
        if (err_long)  n_long_obs++;
    end

    // Reference model: walk the packet through the segments in order
    task automatic expect_packet(input int n, input logic [NS*LB-1:0] seg);
        int len [NS];
        int total = 0;
        int pos = 0;
        for (int i = 0; i < NS; i++) begin
            len[i] = (seg[i*LB +: LB] == 0) ? 1 : int'(seg[i*LB +: LB]);
            total += len[i];
        end
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < len[i] && pos < n; j++) begin
                beat_t b;
                b.d = pkt_d[pos];
                b.u = pkt_u[pos];
                b.l = (j == len[i] - 1) || (pos == n - 1);
                exp_q[i].push_back(b);
                pos++;
            end
        end
        if (n < total) exp_short++;
        else if (n > total) exp_long++;
    endtask

    task automatic fill_packet(input int n);
        pkt_d.delete();
        pkt_u.delete();
        for (int k = 0; k < n; k++) begin
            pkt_d.push_back(DW'($urandom));
            pkt_u.push_back(UW'($urandom));
        end
    endtask

    // Drives one packet; optionally scrambles seg_beats after the first beat is accepted
    task automatic send_packet(input int n, input logic [NS*LB-1:0] seg, input bit scramble, input int gap_pct);
        fill_packet(n);
        expect_packet(n, seg);
        seg_beats = seg;
        for (int k = 0; k < n; k++) begin
            bit hs;
            int waited;
            while (int'($urandom_range(99)) < gap_pct) begin
                i_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            i_tvalid = 1'b1;
            i_tdata  = pkt_d[k];
            i_tuser  = pkt_u[k];
            i_tlast  = (k == n - 1);
            hs = 1'b0;
            waited = 0;
            while (!hs) begin
                @(negedge clk);
                hs = i_tready;
                @(posedge clk); #1;
                waited++;
                if (!hs && waited > 200) begin
                    n_checks++; n_fail++;
                    $display("FAIL handshake_timeout: beat %0d not accepted in %0d cycles, required acceptance", k, waited);
                    i_tvalid = 1'b0;
                    return;
                end
            end
            if (scramble && k == 0) seg_beats = {$urandom, $urandom};
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1; i_tvalid = 1'b1; i_tlast = 1'b0; i_tdata = 8'hA5; i_tuser = '0;
        seg_beats = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (o_tvalid !== '0) begin n_fail++; $display("FAIL reset_tvalid: got %b, required 0", o_tvalid); end
        n_checks++; if (i_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b, required 0", i_tready); end
        n_checks++; if ({err_short, err_long} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b, required 00", {err_short, err_long}); end
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        areset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        // exact length, short, long followed by a normal packet that must restart on s0
        send_packet(5, {16'd3, 16'd2}, 1'b0, 0);
        send_packet(3, {16'd3, 16'd2}, 1'b0, 0);
        send_packet(7, {16'd3, 16'd2}, 1'b0, 0);
        send_packet(5, {16'd3, 16'd2}, 1'b0, 0);
        repeat (3) @(posedge clk); #1;
        n_checks++; if (exp_q[0].size() + exp_q[1].size() !== 0) begin n_fail++; $display("FAIL directed_drain: got %0d beats outstanding, required 0", exp_q[0].size() + exp_q[1].size()); end
        n_checks++; if (n_short_obs !== exp_short) begin n_fail++; $display("FAIL directed_err_short: got %0d pulses, required %0d", n_short_obs, exp_short); end
        n_checks++; if (n_long_obs !== exp_long) begin n_fail++; $display("FAIL directed_err_long: got %0d pulses, required %0d", n_long_obs, exp_long); end
    endtask

    task automatic test_stall();
        bp_mode = 2; man_rdy = '1;
        @(posedge clk); #1;
        fill_packet(5);
        expect_packet(5, {16'd3, 16'd2});
        seg_beats = {16'd3, 16'd2};
        i_tvalid = 1'b1; i_tlast = 1'b0; i_tdata = pkt_d[0]; i_tuser = pkt_u[0];
        @(negedge clk);
        n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_hi: got %b, required 1", i_tready); end
        @(posedge clk); #1;
        i_tdata = pkt_d[1]; i_tuser = pkt_u[1];
        man_rdy = 2'b10;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (i_tready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_lo: got %b, required 0", i_tready); end
            n_checks++; if (o_tvalid !== 2'b01) begin n_fail++; $display("FAIL stall_tvalid: got %b, required 01", o_tvalid); end
            n_checks++; if (o_tdata[DW-1:0] !== pkt_d[1] || o_tlast[0] !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got d=%h l=%b, required d=%h l=1", o_tdata[DW-1:0], o_tlast[0], pkt_d[1]); end
            @(posedge clk); #1;
        end
        man_rdy = '1;
        @(negedge clk);
        n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b, required 1", i_tready); end
        @(posedge clk); #1;
        for (int k = 2; k < 5; k++) begin
            i_tdata = pkt_d[k]; i_tuser = pkt_u[k]; i_tlast = (k == 4);
            @(negedge clk);
            n_checks++; if (o_tvalid !== 2'b10) begin n_fail++; $display("FAIL stall_s1_tvalid: got %b, required 10", o_tvalid); end
            @(posedge clk); #1;
        end
        i_tvalid = 1'b0; i_tlast = 1'b0;
        bp_mode = 0;
        repeat (2) @(posedge clk); #1;
        n_checks++; if (exp_q[0].size() + exp_q[1].size() !== 0) begin n_fail++; $display("FAIL stall_drain: got %0d beats outstanding, required 0", exp_q[0].size() + exp_q[1].size()); end
    endtask

    task automatic test_zero_len_reset();
        send_packet(2, '0, 1'b0, 0);
        // start another packet, accept one beat, then reset mid-packet
        fill_packet(1);
        begin
            beat_t b;
            b.d = pkt_d[0]; b.u = pkt_u[0]; b.l = 1'b1;
            exp_q[0].push_back(b);
        end
        seg_beats = '0;
        i_tvalid = 1'b1; i_tlast = 1'b0; i_tdata = pkt_d[0]; i_tuser = pkt_u[0];
        @(posedge clk); #1;
        areset = 1'b1;
        i_tdata = 8'h3C;
        @(negedge clk);
        n_checks++; if (o_tvalid !== '0 || i_tready !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got tvalid=%b tready=%b, required 0 0", o_tvalid, i_tready); end
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        areset = 1'b0;
        @(posedge clk); #1;
        send_packet(2, '0, 1'b0, 0);
        repeat (2) @(posedge clk); #1;
        n_checks++; if (exp_q[0].size() + exp_q[1].size() !== 0) begin n_fail++; $display("FAIL zero_reset_drain: got %0d beats outstanding, required 0", exp_q[0].size() + exp_q[1].size()); end
        n_checks++; if (n_short_obs !== exp_short || n_long_obs !== exp_long) begin n_fail++; $display("FAIL zero_reset_err: got short=%0d long=%0d, required %0d %0d", n_short_obs, n_long_obs, exp_short, exp_long); end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 10; p++) begin
            logic [NS*LB-1:0] seg;
            seg = {LB'($urandom_range(3)), LB'($urandom_range(3))};
            send_packet($urandom_range(1, 8), seg, 1'b0, 0);
        end
        repeat (2) @(posedge clk); #1;
        n_checks++; if (exp_q[0].size() + exp_q[1].size() !== 0) begin n_fail++; $display("FAIL b2b_drain: got %0d beats outstanding, required 0", exp_q[0].size() + exp_q[1].size()); end
        n_checks++; if (n_short_obs !== exp_short || n_long_obs !== exp_long) begin n_fail++; $display("FAIL b2b_err: got short=%0d long=%0d, required %0d %0d", n_short_obs, n_long_obs, exp_short, exp_long); end
    endtask

    task automatic test_random();
        bp_mode = 1;
        for (int p = 0; p < 40; p++) begin
            logic [NS*LB-1:0] seg;
            seg = {LB'($urandom_range(4)), LB'($urandom_range(4))};
            send_packet($urandom_range(1, 10), seg, 1'b1, 30);
        end
        bp_mode = 0;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (exp_q[0].size() + exp_q[1].size() !== 0) begin n_fail++; $display("FAIL random_drain: got %0d beats outstanding, required 0", exp_q[0].size() + exp_q[1].size()); end
        n_checks++; if (n_short_obs !== exp_short) begin n_fail++; $display("FAIL random_err_short: got %0d pulses, required %0d", n_short_obs, exp_short); end
        n_checks++; if (n_long_obs !== exp_long) begin n_fail++; $display("FAIL random_err_long: got %0d pulses, required %0d", n_long_obs, exp_long); end
        n_checks++; if (n_viol !== 0) begin n_fail++; $display("FAIL exclusivity: got %0d cycles with multiple tvalid or both errors, required 0", n_viol); end
    endtask

    initial begin
        o_tready = '1;
        test_reset();
        test_directed();
        test_stall();
        test_zero_len_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
